// File: rtl/multi_rate_divider_pkg.sv
// multi_rate_divider_pkg: shared defaults and clock constants for the multi-rate divider
package multi_rate_divider_pkg;
    localparam int          SYS_CLK_HZ      = 100_000_000;
    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 50_000_000;
endpackage

// File: rtl/divider_channel.sv
// divider_channel: one divide-by-D channel with deferred divisor update, tick and square-wave outputs
module divider_channel
    import multi_rate_divider_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    input  logic             sync_i,
    output logic             tick_o,
    output logic             divclk_o
);
    logic [CNT_W-1:0] div_q, div_d, pval_q, pval_d, cnt_q, cnt_d, lim;
    logic             pend_q, pend_d, tick_q, tick_d, clk_q, clk_d, pend_now, term, apply;

    // A load in the same cycle as an apply point is folded in, so the newest value wins
    always_comb begin
        lim      = (div_q == '0) ? '0 : div_q - 1'b1;
        pval_d   = load_i ? div_i : pval_q;
        pend_now = load_i | pend_q;
        term     = en_i && (cnt_q >= lim);
        apply    = pend_now && (sync_i || !en_i || term);
        div_d    = apply ? pval_d : div_q;
        pend_d   = pend_now && !apply;
        cnt_d    = (sync_i || term || (apply && !en_i)) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
        tick_d   = !sync_i && term;
        clk_d    = sync_i ? 1'b0 : clk_q ^ term;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= CNT_W'(DEFAULT_DIV);
            pval_q <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_o   = tick_q;
    assign divclk_o = clk_q;
endmodule

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent programmable clock dividers sharing one sync strobe
module multi_rate_divider
    import multi_rate_divider_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       divclk
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        divider_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk_i    (sysclk),
            .rst_i    (reset),
            .en_i     (enable[i]),
            .div_i    (div_val[i*CNT_W +: CNT_W]),
            .load_i   (div_load[i]),
            .sync_i   (sync),
            .tick_o   (tick[i]),
            .divclk_o (divclk[i])
        );
    end
endmodule

// File: tb/tb_multi_rate_divider.sv
// tb_multi_rate_divider: directed and randomized checks of the divider against a period-level model
module tb_multi_rate_divider;
    import multi_rate_divider_pkg::*;
    localparam int N = 4;
    localparam int W = 32;

    logic           sysclk = 1'b0, reset = 1'b1, sync = 1'b0;
    logic [N-1:0]   enable = '0, div_load = '0, tick, divclk;
    logic [N*W-1:0] div_val = '0;
    int             checks = 0, errors = 0;

    longint m_div[N], m_pval[N], m_el[N];
    bit     m_pend[N], m_tick[N], m_clk[N];

    multi_rate_divider #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEFAULT_DIV_DEF)) dut (
        .sysclk(sysclk), .reset(reset), .enable(enable), .div_val(div_val),
        .div_load(div_load), .sync(sync), .tick(tick), .divclk(divclk)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model tracks elapsed cycles within the current period and applies rules from the requirements
    task automatic model();
        for (int i = 0; i < N; i++) begin
            longint pv, per;
            bit     pe;
            if (reset) begin
                m_div[i] = DEFAULT_DIV_DEF; m_pval[i] = 0; m_pend[i] = 0;
                m_el[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
                continue;
            end
            pv = div_load[i] ? longint'(div_val[i*W +: W]) : m_pval[i];
            pe = div_load[i] | m_pend[i];
            m_pval[i] = pv;
            m_pend[i] = pe;
            if (sync) begin
                m_el[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
                if (pe) begin m_div[i] = pv; m_pend[i] = 0; end
            end else if (!enable[i]) begin
                m_tick[i] = 0;
                if (pe) begin m_div[i] = pv; m_pend[i] = 0; m_el[i] = 0; end
            end else begin
                per = (m_div[i] == 0) ? 1 : m_div[i];
                if (m_el[i] + 1 >= per) begin
                    m_el[i] = 0; m_tick[i] = 1; m_clk[i] = !m_clk[i];
                    if (pe) begin m_div[i] = pv; m_pend[i] = 0; end
                end else begin
                    m_el[i]++; m_tick[i] = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        model();
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("model_tick%0d", i), 64'(tick[i]), 64'(m_tick[i]));
            check($sformatf("model_divclk%0d", i), 64'(divclk[i]), 64'(m_clk[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = '0; div_load = '0; sync = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic load_disabled(input int ch, input int d);
        enable[ch] = 1'b0;
        div_val[ch*W +: W] = W'(d);
        div_load[ch] = 1'b1;
        cyc();
        div_load[ch] = 1'b0;
        cyc();
    endtask

    initial begin
        logic p0, p1, held;
        do_reset();
        check("reset_tick", 64'(tick), 64'(0));
        check("reset_divclk", 64'(divclk), 64'(0));

        load_disabled(0, 4);
        enable[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("d4_tick", 64'(tick[0]), 64'(k % 4 == 0));
            check("d4_divclk", 64'(divclk[0]), 64'((k / 4) % 2));
        end

        do_reset();
        load_disabled(0, 5);
        enable[0] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 2) begin div_val[0 +: W] = W'(2); div_load[0] = 1'b1; end
            cyc();
            div_load[0] = 1'b0;
            check("reload_tick", 64'(tick[0]), 64'(k == 5 || (k > 5 && (k - 5) % 2 == 0)));
        end

        do_reset();
        load_disabled(0, 0);
        load_disabled(1, 1);
        enable[1:0] = 2'b11;
        cyc();
        for (int k = 0; k < 6; k++) begin
            p0 = divclk[0]; p1 = divclk[1];
            cyc();
            check("d0_tick", 64'(tick[0]), 64'(1));
            check("d1_tick", 64'(tick[1]), 64'(1));
            check("d0_toggle", 64'(divclk[0]), 64'(!p0));
            check("d1_toggle", 64'(divclk[1]), 64'(!p1));
        end

        do_reset();
        load_disabled(0, 3);
        load_disabled(1, 7);
        enable[1:0] = 2'b11;
        repeat (5) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync_tick", 64'(tick[1:0]), 64'(0));
        check("sync_divclk", 64'(divclk[1:0]), 64'(0));
        for (int k = 1; k <= 7; k++) begin
            cyc();
            check("sync_t0", 64'(tick[0]), 64'(k % 3 == 0));
            check("sync_t1", 64'(tick[1]), 64'(k == 7));
        end

        do_reset();
        load_disabled(0, 6);
        enable[0] = 1'b1;
        cyc(); cyc();
        enable[0] = 1'b0;
        held = divclk[0];
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("dis_tick", 64'(tick[0]), 64'(0));
            check("dis_divclk", 64'(divclk[0]), 64'(held));
        end
        enable[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("reen_tick", 64'(tick[0]), 64'(k == 4));
        end

        do_reset();
        load_disabled(0, 8);
        enable[0] = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        check("midrst_tick", 64'(tick[0]), 64'(0));
        check("midrst_divclk", 64'(divclk[0]), 64'(0));
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("postrst_tick", 64'(tick[0]), 64'(0));
        end

        do_reset();
        for (int i = 0; i < N; i++) load_disabled(i, $urandom_range(0, 9));
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                enable[i]   = ($urandom_range(0, 9) != 0);
                div_load[i] = ($urandom_range(0, 24) == 0);
                div_val[i*W +: W] = W'($urandom_range(0, 9));
            end
            sync  = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 499) == 0);
            cyc();
            if (reset) begin
                reset = 1'b0;
                for (int i = 0; i < N; i++) load_disabled(i, $urandom_range(0, 9));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_rate_divider.md
MULTI_RATE_DIVIDER -- requirements
Module: multi_rate_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 32: divisor and counter width per channel.
REQ-003 Parameter DEFAULT_DIV, default 50_000_000: divisor loaded into every channel at reset.
REQ-004 sysclk  in  1: single system clock (100 MHz); all logic on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 enable  in  NUM_CH: per-channel run enable.
REQ-007 div_val  in  NUM_CH*CNT_W: flattened divisors; channel i uses bits [i*CNT_W +: CNT_W].
REQ-008 div_load  in  NUM_CH: per-channel strobe capturing the div_val slice as pending divisor.
REQ-009 sync  in  1: global phase-alignment strobe.
REQ-010 tick  out  NUM_CH: registered one-cycle pulse per channel period.
REQ-011 divclk  out  NUM_CH: registered square wave, toggles on every tick.

Function
REQ-012 Each channel SHALL hold an active divisor D (CNT_W bits), a pending divisor P, a pending flag, a counter, tick and divclk registers.
REQ-013 Effective limit L = max(D,1) - 1; D = 0 SHALL behave exactly as D = 1.
REQ-014 Enabled channel, counter < L: counter increments, tick <= 0.
REQ-015 Enabled channel, counter == L: counter <= 0, tick <= 1, divclk <= ~divclk.
REQ-016 Result: tick period D cycles, high exactly 1 cycle; divclk period 2*D cycles, 50 % duty.
REQ-017 Enabled, D = N, counter starting at 0: first tick SHALL be high in the cycle following the N-th rising edge.
REQ-018 enable[i] low: counter and divclk hold, tick <= 0; re-enable resumes from the held count.
REQ-019 div_load[i] high: P <= slice, pending <= 1; a later load before application overwrites P.
REQ-020 Pending applies (D <= P, pending <= 0) at the next terminal count of an enabled channel; the new D governs the following period; no short or truncated period is produced.
REQ-021 Pending applies immediately (next edge) when the channel is disabled, together with counter <= 0.
REQ-022 div_load coincident with terminal count: the value loaded that cycle is the one applied (load captured and applied on the same edge).
REQ-023 sync high: every channel counter <= 0, divclk <= 0, tick <= 0, pending divisor applied if set; enabled and disabled channels alike.
REQ-024 Priority per channel: reset > sync > terminal count > increment.
REQ-025 Counter comparison and increment SHALL be CNT_W wide, unsigned; counter never exceeds L, even when D decreases.
REQ-026 Channels SHALL be fully independent except for sysclk, reset and sync.

Reset
REQ-027 On reset: counter 0, D = DEFAULT_DIV, P = 0, pending 0, tick 0, divclk 0 for every channel.
REQ-028 Reset asserted mid-period SHALL abort the period; no tick is emitted in the cycle after reset.
REQ-029 First tick after reset release with enable high and D = DEFAULT_DIV SHALL occur per REQ-017.

Structure
REQ-030 Shared package multi_rate_divider_pkg SHALL hold CNT_W and DEFAULT_DIV defaults and the SYS_CLK_HZ = 100_000_000 constant.
REQ-031 One sub-module divider_channel (single-channel counter, pending-divisor logic, tick/divclk regs), instantiated NUM_CH times by generate.
REQ-032 Top level contains only slicing of div_val and the generate loop; no combinational path from inputs to outputs.

Verification
REQ-033 Reset, enable=1, D=4 loaded via disabled load: tick high cycles 4, 8, 12; divclk toggles at those cycles.
REQ-034 D=5 running, div_load value 2 at count 1 -> current period completes at 5 cycles, then ticks every 2 cycles.
REQ-035 D=0 and D=1 -> tick high every cycle, divclk toggles every cycle.
REQ-036 Ch0 D=3, ch1 D=7, pulse sync mid-period -> both counters 0, divclk 0, next ticks 3 and 7 cycles after sync.
REQ-037 D=6, enable low for 10 cycles at count 2 -> no ticks, divclk steady; tick 4 cycles after re-enable.
REQ-038 Reset pulsed at count 3 of D=8 -> tick and divclk 0, D=DEFAULT_DIV, no tick in cycle after release.
